clock_half_sec: RTL and testbench
=================================

Name: clock_half_sec

Overview:
- Clock divider. Derives a slow, 50%-duty, glitch-free square wave `clock_half` from the 100 MHz system clock.
- Default period is 0.5 s: 0.25 s high, 0.25 s low.
- Drives blink-rate logic in the vault lock controller, which samples `clock_half` edges to toggle its LED bank.
- Also provides single-cycle strobes in the `clk` domain, so downstream logic can avoid clocking on a derived signal.

Parameters:
- CLK_FREQ_HZ, 100_000_000, input clock frequency in Hz.
- PERIOD_MS, 500, full period of `clock_half` in milliseconds.
- HALF_COUNT (derived, localparam), CLK_FREQ_HZ/1000*PERIOD_MS/2, `clk` cycles per `clock_half` phase. Default is 25_000_000.
- CNT_W (derived, localparam), $clog2(HALF_COUNT), counter width. Minimum 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable. When 0, counter and outputs hold.
- clock_half  output  1  divided square wave, driven directly from a flop.
- tick_rise  output  1  one-`clk` pulse in the cycle `clock_half` becomes 1.
- tick_fall  output  1  one-`clk` pulse in the cycle `clock_half` becomes 0.

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous-release usage assumed): counter=0, clock_half=0, tick_rise=0, tick_fall=0. Reset mid-period discards the partial count.
- Each rising clk edge with en=1:
  - If counter==HALF_COUNT-1: counter<=0 and clock_half<=~clock_half.
  - Otherwise: counter<=counter+1.
- en=0: counter, clock_half hold; tick_rise and tick_fall are 0.
- First `clock_half` rise occurs HALF_COUNT enabled cycles after reset release. Each phase thereafter is exactly HALF_COUNT enabled cycles.
- tick_rise and tick_fall are registered and asserted in the same cycle the new `clock_half` value appears. Never both high. Each is high for exactly one cycle per event.
- HALF_COUNT==1: clock_half toggles every enabled cycle, and the ticks alternate every cycle.
- Counter wraps only via the compare. It never reaches HALF_COUNT.
- Elaboration check: HALF_COUNT>=1, else $error or a fatal assertion.
- No combinational path from any input to any output.

Decomposition:
- Package clk_div_pkg holds:
  - SYS_CLK_FREQ_HZ = 100_000_000
  - BLINK_PERIOD_MS = 500
  - a function computing half-count from frequency and period.
- No sub-module. A single counter plus toggle flop is sufficient.
- Optional SVA block inside the module checks:
  - phase length == HALF_COUNT
  - tick exclusivity

Test Plan:
1. Setup: CLK_FREQ_HZ=1000, PERIOD_MS=8 (HALF_COUNT=4), en=1, release reset. Required: clock_half=0 for cycles 1–3, rises on edge 4 with tick_rise=1 for that cycle only; falls on edge 8 with tick_fall=1; period is 8 cycles.
2. Reset mid-phase: assert rst_n=0 asynchronously at cycle 6. Required: clock_half=0 and ticks=0 immediately, without waiting for a clk edge; after release, first rise again occurs at enabled cycle 4.
3. Enable gating: drop en for 5 cycles at counter=2. Required: clock_half and counter frozen, no ticks; resuming, the toggle occurs after 2 more enabled cycles.
4. HALF_COUNT=1 (CLK_FREQ_HZ=1000, PERIOD_MS=2). Required: clock_half toggles every cycle; tick_rise and tick_fall alternate and are never simultaneous.
5. Defaults: run 100 M cycles. Required: exactly 2 rising and 2 falling edges of clock_half, each phase exactly 25_000_000 cycles.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared clock-divider constants and the half-period count helper.
// Imported by the slow-clock generators in this slice.
package clk_div_pkg;

    localparam int unsigned SYS_CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned BLINK_PERIOD_MS = 500;

    // Divide by 1000 first so the intermediate product stays in 32 bits
    function automatic int unsigned half_count(
        input int unsigned freq_hz,
        input int unsigned period_ms
    );
        return freq_hz / 1000 * period_ms / 2;
    endfunction

endpackage

// File: rtl/clock_half_sec.sv
// Divides clk down to a 50%-duty square wave clock_half.
// Also emits clk-domain strobes on each clock_half edge.
module clock_half_sec
    import clk_div_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = SYS_CLK_FREQ_HZ,
    parameter int unsigned PERIOD_MS   = BLINK_PERIOD_MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic clock_half,
    output logic tick_rise,
    output logic tick_fall
);

    localparam int unsigned HALF_COUNT = half_count(CLK_FREQ_HZ, PERIOD_MS);
    localparam int unsigned CNT_W =
        (HALF_COUNT > 1) ? $clog2(HALF_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_COUNT - 1);

    generate
        if (HALF_COUNT < 1) begin : g_bad_count
            $error("clock_half_sec: HALF_COUNT must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            clock_half <= 1'b0;
            tick_rise  <= 1'b0;
            tick_fall  <= 1'b0;
        end else begin
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
            if (en) begin
                if (cnt == LAST) begin
                    cnt        <= '0;
                    clock_half <= ~clock_half;
                    // Strobe lines up with the new clock_half value
                    tick_rise  <= ~clock_half;
                    tick_fall  <= clock_half;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    a_tick_excl: assert property (
        @(posedge clk) disable iff (!rst_n) !(tick_rise && tick_fall)
    );

    a_cnt_range: assert property (
        @(posedge clk) disable iff (!rst_n) cnt <= LAST
    );

endmodule

// File: tb/tb_clock_half_sec.sv
// Directed bench for clock_half_sec: half-counts of 4 and 1,
// plus reset behaviour of the default configuration.
module tb_clock_half_sec;

    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic en_a = 1'b0;
    logic rst_n_b = 1'b0;
    logic en_b = 1'b0;
    logic ch_a, tr_a, tf_a;
    logic ch_b, tr_b, tf_b;
    logic ch_c, tr_c, tf_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clock_half_sec #(.CLK_FREQ_HZ(1000), .PERIOD_MS(8)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .en(en_a),
        .clock_half(ch_a), .tick_rise(tr_a), .tick_fall(tf_a)
    );

    clock_half_sec #(.CLK_FREQ_HZ(1000), .PERIOD_MS(2)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .en(en_b),
        .clock_half(ch_b), .tick_rise(tr_b), .tick_fall(tf_b)
    );

    clock_half_sec dut_c (
        .clk(clk), .rst_n(rst_n_a), .en(en_a),
        .clock_half(ch_c), .tick_rise(tr_c), .tick_fall(tf_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {clock_half, tick_rise, tick_fall} after k enabled edges, HALF_COUNT=4
    function automatic logic [2:0] exp4(input int k);
        logic ch;
        logic edge_now;
        ch = ((k / 4) % 2) == 1;
        edge_now = (k > 0) && (k % 4 == 0);
        return {ch, edge_now && ch, edge_now && !ch};
    endfunction

    task automatic reset_a();
        step();
        rst_n_a = 1'b0;
        step();
        rst_n_a = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_a = 1'b0;
        en_a = 1'b1;
        step();
        step();
        checks++;
        if ({ch_a, tr_a, tf_a} !== 3'b000) begin
            errors++;
            $display("FAIL reset_a got=%b want=000", {ch_a, tr_a, tf_a});
        end
        checks++;
        if ({ch_c, tr_c, tf_c} !== 3'b000) begin
            errors++;
            $display("FAIL reset_c got=%b want=000", {ch_c, tr_c, tf_c});
        end
        rst_n_a = 1'b1;
    endtask

    task automatic test_period();
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if ({ch_a, tr_a, tf_a} !== exp4(k)) begin
                errors++;
                $display("FAIL period k=%0d got=%b want=%b",
                         k, {ch_a, tr_a, tf_a}, exp4(k));
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_a();
        for (int k = 1; k <= 6; k++) step();
        checks++;
        if (ch_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got=%b want=1", ch_a);
        end
        #2;
        rst_n_a = 1'b0;
        #1;
        checks++;
        if ({ch_a, tr_a, tf_a} !== 3'b000) begin
            errors++;
            $display("FAIL mid_async got=%b want=000", {ch_a, tr_a, tf_a});
        end
        step();
        rst_n_a = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if ({ch_a, tr_a, tf_a} !== exp4(k)) begin
                errors++;
                $display("FAIL mid_restart k=%0d got=%b want=%b",
                         k, {ch_a, tr_a, tf_a}, exp4(k));
            end
        end
    endtask

    task automatic test_enable();
        reset_a();
        step();
        step();
        en_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if ({ch_a, tr_a, tf_a} !== 3'b000) begin
                errors++;
                $display("FAIL en_hold k=%0d got=%b want=000",
                         k, {ch_a, tr_a, tf_a});
            end
        end
        en_a = 1'b1;
        step();
        checks++;
        if ({ch_a, tr_a, tf_a} !== 3'b000) begin
            errors++;
            $display("FAIL en_resume1 got=%b want=000", {ch_a, tr_a, tf_a});
        end
        step();
        checks++;
        if ({ch_a, tr_a, tf_a} !== 3'b110) begin
            errors++;
            $display("FAIL en_resume2 got=%b want=110", {ch_a, tr_a, tf_a});
        end
        en_a = 1'b0;
        step();
        checks++;
        if ({ch_a, tr_a, tf_a} !== 3'b100) begin
            errors++;
            $display("FAIL en_tick_clr got=%b want=100", {ch_a, tr_a, tf_a});
        end
        en_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if ({ch_a, tr_a, tf_a} !== exp4(k + 4)) begin
                errors++;
                $display("FAIL en_fall k=%0d got=%b want=%b",
                         k, {ch_a, tr_a, tf_a}, exp4(k + 4));
            end
        end
    endtask

    task automatic test_half_one();
        logic [2:0] want;
        rst_n_b = 1'b0;
        en_b = 1'b1;
        step();
        checks++;
        if ({ch_b, tr_b, tf_b} !== 3'b000) begin
            errors++;
            $display("FAIL hc1_reset got=%b want=000", {ch_b, tr_b, tf_b});
        end
        rst_n_b = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            want = (k % 2 == 1) ? 3'b110 : 3'b001;
            checks++;
            if ({ch_b, tr_b, tf_b} !== want) begin
                errors++;
                $display("FAIL hc1 k=%0d got=%b want=%b",
                         k, {ch_b, tr_b, tf_b}, want);
            end
        end
        en_b = 1'b0;
        step();
        checks++;
        if ({ch_b, tr_b, tf_b} !== 3'b000) begin
            errors++;
            $display("FAIL hc1_hold got=%b want=000", {ch_b, tr_b, tf_b});
        end
    endtask

    task automatic test_defaults();
        for (int k = 0; k < 40; k++) step();
        checks++;
        if ({ch_c, tr_c, tf_c} !== 3'b000) begin
            errors++;
            $display("FAIL default_slow got=%b want=000", {ch_c, tr_c, tf_c});
        end
    endtask

    initial begin
        test_reset();
        test_period();
        test_reset_mid();
        test_enable();
        test_half_one();
        test_defaults();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
